// File: rtl/and_gate.sv
// Registered bitwise AND with a valid-qualified pipeline, reduction flags and
// an optional saturating match counter (enabled by defining AND_GATE_STATS_EN).
module and_gate #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_all,
    output logic             out_any,
    output logic [CNT_W-1:0] match_cnt
);

    // Index s holds the contents of pipeline stage s; stage STAGES drives out.
    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1][WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid)
                dat_pipe[1] <= in1 & in2;
            // Data only moves with its valid bit, so each stage holds its last result.
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1])
                    dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out       = dat_pipe[STAGES];
    assign out_valid = vld_pipe[STAGES];
    assign out_all   = &out;
    assign out_any   = |out;

`ifdef AND_GATE_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (out_valid && out_all && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: truth table, reset, wide operands, streaming,
// saturating counter and reset/valid collision, across three configurations.
module tb_and_gate;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // u1: WIDTH=1 STAGES=1
    logic        a1, b1, v1;
    logic [0:0]  o1;
    logic        ov1, all1, any1;
    logic [15:0] mc1;
    // u8: WIDTH=8 STAGES=3
    logic [7:0]  a8, b8, o8;
    logic        v8, ov8, all8, any8;
    logic [15:0] mc8;
    // uc: WIDTH=1 STAGES=1 CNT_W=2
    logic        ac, bc, vc;
    logic [0:0]  oc;
    logic        ovc, allc, anyc;
    logic [1:0]  mcc;

    and_gate #(.WIDTH(1), .STAGES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in1(a1), .in2(b1), .in_valid(v1),
        .out(o1), .out_valid(ov1), .out_all(all1), .out_any(any1), .match_cnt(mc1));
    and_gate #(.WIDTH(8), .STAGES(3), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .in1(a8), .in2(b8), .in_valid(v8),
        .out(o8), .out_valid(ov8), .out_all(all8), .out_any(any8), .match_cnt(mc8));
    and_gate #(.WIDTH(1), .STAGES(1), .CNT_W(2)) uc (
        .clk(clk), .rst(rst), .in1(ac), .in2(bc), .in_valid(vc),
        .out(oc), .out_valid(ovc), .out_all(allc), .out_any(anyc), .match_cnt(mcc));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sa [4];
    logic [7:0] sb [4];
    logic [7:0] sr [4];
    logic [1:0] cexp [5];

    initial begin
        sa = '{8'hA5, 8'hFF, 8'h3C, 8'h77};
        sb = '{8'h0F, 8'h81, 8'hC3, 8'hEE};
        sr = '{8'h05, 8'h81, 8'h00, 8'h66};
`ifdef AND_GATE_STATS_EN
        cexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        cexp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        rst = 1'b1;
        {a1, b1, v1} = '0; {a8, b8, v8} = '0; {ac, bc, vc} = '0;
        step(); step();

        chk("rst_out1",   64'(o1),   64'd0);
        chk("rst_vld1",   64'(ov1),  64'd0);
        chk("rst_all1",   64'(all1), 64'd0);
        chk("rst_any1",   64'(any1), 64'd0);
        chk("rst_cnt1",   64'(mc1),  64'd0);
        chk("rst_out8",   64'(o8),   64'd0);
        chk("rst_vld8",   64'(ov8),  64'd0);
        rst = 1'b0;

        // Truth table, each vector held for ten cycles
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0]; v1 = 1'b1;
            step();
            chk("tt_out_first", 64'(o1),  64'(i == 3));
            chk("tt_vld_first", 64'(ov1), 64'd1);
            for (int k = 0; k < 9; k++) step();
            chk("tt_out_held",  64'(o1),  64'(i == 3));
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        step();
        chk("tt_idle_vld",  64'(ov1),  64'd0);
        chk("tt_idle_hold", 64'(o1),   64'd1);
        chk("tt_idle_all",  64'(all1), 64'd1);

        // Reset with (1,1) in flight in the 3-stage unit
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        step();
        v8 = 1'b0; rst = 1'b1;
        step();
        chk("mrst_out8", 64'(o8),  64'd0);
        chk("mrst_vld8", 64'(ov8), 64'd0);
        chk("mrst_out1", 64'(o1),  64'd0);
        chk("mrst_vld1", 64'(ov1), 64'd0);
        chk("mrst_cnt1", 64'(mc1), 64'd0);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        step();
        chk("post_rst_vld1", 64'(ov1), 64'd1);
        chk("post_rst_out1", 64'(o1),  64'd1);
        chk("flush_vld8",    64'(ov8), 64'd0);
        v1 = 1'b0;
        step(); step();
        chk("flush_vld8_b",  64'(ov8), 64'd0);
        chk("flush_out8",    64'(o8),  64'd0);

        // Wide operands, 3-cycle latency
        a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("wide_lat1", 64'(ov8), 64'd0);
        step();
        chk("wide_lat2", 64'(ov8), 64'd0);
        step();
        chk("wide_vld",  64'(ov8),  64'd1);
        chk("wide_out",  64'(o8),   64'h30);
        chk("wide_any",  64'(any8), 64'd1);
        chk("wide_all",  64'(all8), 64'd0);
        a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        step();
        v8 = 1'b0;
        step(); step();
        chk("wide_ff_out", 64'(o8),   64'hFF);
        chk("wide_ff_all", 64'(all8), 64'd1);

        // Streaming: four back-to-back inputs
        for (int i = 0; i < 4; i++) begin
            a8 = sa[i]; b8 = sb[i]; v8 = 1'b1;
            step();
            if (i >= 2) begin
                chk("strm_vld", 64'(ov8), 64'd1);
                chk("strm_out", 64'(o8),  64'(sr[i-2]));
            end
        end
        v8 = 1'b0;
        for (int i = 2; i < 4; i++) begin
            step();
            chk("strm_vld_tail", 64'(ov8), 64'd1);
            chk("strm_out_tail", 64'(o8),  64'(sr[i]));
        end
        step();
        chk("strm_idle_vld", 64'(ov8),  64'd0);
        chk("strm_idle_out", 64'(o8),   64'h66);
        chk("strm_idle_any", 64'(any8), 64'd1);

        // Saturating counter, CNT_W = 2
        ac = 1'b1; bc = 1'b1; vc = 1'b1;
        step();
        chk("cnt_first_vld", 64'(ovc), 64'd1);
        chk("cnt_lag",       64'(mcc), 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) vc = 1'b0;
            step();
            chk("cnt_val", 64'(mcc), 64'(cexp[i]));
        end

        // rst and in_valid on the same edge: input dropped
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1; rst = 1'b1;
        step();
        chk("coll_vld_rst", 64'(ov1), 64'd0);
        chk("coll_out_rst", 64'(o1),  64'd0);
        rst = 1'b0; v1 = 1'b0;
        step();
        chk("coll_vld_after", 64'(ov1), 64'd0);
        chk("coll_out_after", 64'(o1),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
